// File: rtl/demultiplexer1to16_buf_if.sv
// Handshake bundle for the 1-to-16 buffered demultiplexer.
// Single input stream, sixteen independent output lanes.
interface demultiplexer1to16_buf_if #(
  parameter int W = 4
);
  logic            inp_valid;
  logic [W-1:0]    inp_data;
  logic [3:0]      select;
  logic            broadcast;
  logic            inp_ready;
  logic [16*W-1:0] out_data;
  logic [15:0]     out_valid;
  logic [15:0]     out_ready;
  logic [4:0]      occupancy;

  modport master (
    output inp_valid,
    output inp_data,
    output select,
    output broadcast,
    output out_ready,
    input  inp_ready,
    input  out_data,
    input  out_valid,
    input  occupancy
  );

  modport slave (
    input  inp_valid,
    input  inp_data,
    input  select,
    input  broadcast,
    input  out_ready,
    output inp_ready,
    output out_data,
    output out_valid,
    output occupancy
  );
endinterface

// File: rtl/demultiplexer1to16_buf.sv
// Registered 1-to-16 demux with per-lane holding buffers.
// Lanes refill in the same cycle they drain.
module demultiplexer1to16_buf #(
  parameter int W = 4
) (
  input logic clk,
  input logic reset,
  demultiplexer1to16_buf_if.slave bus
);

  logic [W-1:0] data_q [16];
  logic [15:0]  valid_q;
  logic [4:0]   occ_q;

  logic [15:0]  free;
  logic [15:0]  sel_oh;
  logic [15:0]  drain;
  logic [15:0]  load;
  logic [15:0]  valid_n;
  logic [4:0]   occ_n;
  logic         rdy;

  assign sel_oh = 16'h0001 << bus.select;
  assign free   = ~valid_q | bus.out_ready;
  assign drain  = valid_q & bus.out_ready;

  always_comb begin
    rdy = 1'b0;
    if (!reset) begin
      if (bus.broadcast) rdy = &free;
      else               rdy = |(free & sel_oh);
    end
  end

  always_comb begin
    load = '0;
    if (bus.inp_valid && rdy) begin
      if (bus.broadcast) load = '1;
      else               load = sel_oh;
    end
  end

  assign valid_n = (valid_q & ~drain) | load;

  // Occupancy is derived from the next valid vector so it can never drift.
  always_comb begin
    occ_n = '0;
    for (int i = 0; i < 16; i++) begin
      occ_n = occ_n + {4'd0, valid_n[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < 16; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_n;
      occ_q   <= occ_n;
      for (int i = 0; i < 16; i++) begin
        if (load[i]) data_q[i] <= bus.inp_data;
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < 16; i++) begin
      bus.out_data[i*W +: W] = data_q[i];
    end
  end

  assign bus.inp_ready = rdy;
  assign bus.out_valid = valid_q;
  assign bus.occupancy = occ_q;

endmodule
